gate_model_seq: RTL and testbench

Test sequencer for the combinational gate models in the gate library (13 inputs, 10 outputs per model). It drives input vectors into one attached gate model and holds each vector stable for a programmable settle time. It then samples the model outputs and compacts them into a 16-bit MISR signature, which is compared against an expected value to produce a pass/fail verdict. It sits between the simulator's stimulus source and one gate model instance. Vectors come either from an internal exhaustive counter sweep or from an external valid/ready vector stream.

---
 rtl/gate_model_seq_pkg.sv | 27 ++
 rtl/gate_model_seq_if.sv | 37 +++
 rtl/gate_model_seq_misr16.sv | 26 ++
 rtl/gate_model_seq.sv | 148 ++++++++++++++
 tb/tb_gate_model_seq.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_model_seq_pkg.sv
// Shared types and constants for the gate-model test sequencer.
package gate_seq_pkg;

  localparam int SIG_W = 16;
  localparam logic [SIG_W-1:0] MISR_SEED = 16'hFFFF;
  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [SIG_W-1:0] MISR_TAPS = 16'hB400;
  localparam logic [SIG_W-1:0] COUNT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_FINISH  = 3'd4
  } seq_state_t;

  // One MISR step: shift left with XOR-of-taps feedback, then fold in the
  // (already zero-extended) response word.
  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] sig,
                                                 input logic [SIG_W-1:0] din);
    logic fb;
    fb = ^(sig & MISR_TAPS);
    return {sig[SIG_W-2:0], fb} ^ din;
  endfunction

endpackage

// File: rtl/gate_model_seq_if.sv
// Bundle of control, vector-stream, gate-model and result signals between the
// stimulus side (master) and the sequencer (slave).
interface gate_model_seq_if
  import gate_seq_pkg::*;
#(
  parameter int N_IN  = 13,
  parameter int N_OUT = 10
) ();

  logic             start;
  logic             mode;
  logic             vec_valid;
  logic [N_IN-1:0]  vec_data;
  logic             vec_last;
  logic             vec_ready;
  logic [N_IN-1:0]  dut_in;
  logic [N_OUT-1:0] dut_out;
  logic [SIG_W-1:0] exp_sig;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;
  logic [15:0]      vec_count;

  // Stimulus source plus the attached gate model.
  modport master (
    output start, mode, vec_valid, vec_data, vec_last, dut_out, exp_sig,
    input  vec_ready, dut_in, busy, done, pass, signature, vec_count
  );

  // The sequencer itself.
  modport slave (
    input  start, mode, vec_valid, vec_data, vec_last, dut_out, exp_sig,
    output vec_ready, dut_in, busy, done, pass, signature, vec_count
  );

endinterface

// File: rtl/gate_model_seq_misr16.sv
// 16-bit multiple-input signature register compacting gate-model responses.
module misr16
  import gate_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             en,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] r_sig;

  // Reseed on reset or run start; otherwise fold in one response per enable.
  always_ff @(posedge clk) begin
    if (rst || init) begin
      r_sig <= MISR_SEED;
    end else if (en) begin
      r_sig <= misr_next(r_sig, din);
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/gate_model_seq.sv
// Test sequencer: applies vectors to one combinational gate model, waits a
// settle time, captures its outputs into a MISR and reports pass/fail.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start; outputs hold results of the last run
// ST_FETCH   | load next vector (sweep counter, or wait for stream beat)
// ST_SETTLE  | hold dut_in stable while the settle down-counter runs
// ST_CAPTURE | fold dut_out into the MISR, count the vector, pick next
// ST_FINISH  | pulse done and register the signature comparison
module gate_model_seq
  import gate_seq_pkg::*;
#(
  parameter int N_IN   = 13,
  parameter int N_OUT  = 10,
  parameter int SETTLE = 2
) (
  input logic           clk,
  input logic           rst,
  gate_model_seq_if.slave bus
);

  localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE);
  // With no settle time the FSM goes straight from FETCH to CAPTURE.
  localparam seq_state_t POST_FETCH = (SETTLE > 0) ? ST_SETTLE : ST_CAPTURE;

  seq_state_t       r_state;
  logic             r_mode;
  logic             r_last;
  logic [N_IN-1:0]  r_sweep;
  logic [CNT_W-1:0] r_settle_cnt;
  logic [N_IN-1:0]  r_dut_in;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [15:0]      r_vec_count;

  logic             w_start_accept;
  logic             w_vec_ready;
  logic             w_fetch_go;
  logic             w_capture;
  logic             w_last_vec;
  logic [N_OUT-1:0] w_dut_out;
  logic [SIG_W-1:0] w_misr_din;
  logic [SIG_W-1:0] w_sig;

  assign w_start_accept = (r_state == ST_IDLE) && bus.start;
  // Ready depends only on the state and the mode latched at start, never on
  // vec_valid, so the stream source cannot form a combinational loop.
  assign w_vec_ready    = (r_state == ST_FETCH) && r_mode;
  assign w_fetch_go     = r_mode ? bus.vec_valid : 1'b1;
  assign w_capture      = (r_state == ST_CAPTURE);
  assign w_last_vec     = r_mode ? r_last : (&r_sweep);
  assign w_dut_out      = bus.dut_out;
  assign w_misr_din     = SIG_W'(w_dut_out);

  misr16 u_misr (
    .clk  (clk),
    .rst  (rst),
    .init (w_start_accept),
    .en   (w_capture),
    .din  (w_misr_din),
    .sig  (w_sig)
  );

  // Sequencer FSM with all datapath registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_mode       <= 1'b0;
      r_last       <= 1'b0;
      r_sweep      <= '0;
      r_settle_cnt <= '0;
      r_dut_in     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_vec_count  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_mode      <= bus.mode;
            r_last      <= 1'b0;
            r_sweep     <= '0;
            r_vec_count <= '0;
            r_pass      <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (w_fetch_go) begin
            r_dut_in     <= r_mode ? bus.vec_data : r_sweep;
            r_last       <= r_mode ? bus.vec_last : 1'b0;
            r_settle_cnt <= SETTLE_LOAD;
            r_state      <= POST_FETCH;
          end
        end

        ST_SETTLE: begin
          if (r_settle_cnt <= CNT_W'(1)) begin
            r_state <= ST_CAPTURE;
          end else begin
            r_settle_cnt <= r_settle_cnt - CNT_W'(1);
          end
        end

        ST_CAPTURE: begin
          if (r_vec_count != COUNT_MAX) begin
            r_vec_count <= r_vec_count + 16'd1;
          end
          if (w_last_vec) begin
            r_done  <= 1'b1;
            r_state <= ST_FINISH;
          end else begin
            // Not last, so an all-ones sweep counter never gets here: no wrap.
            r_sweep <= r_sweep + N_IN'(1);
            r_state <= ST_FETCH;
          end
        end

        ST_FINISH: begin
          r_pass  <= (w_sig == bus.exp_sig);
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.vec_ready = w_vec_ready;
  assign bus.dut_in    = r_dut_in;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.signature = w_sig;
  assign bus.vec_count = r_vec_count;

endmodule

// File: tb/tb_gate_model_seq.sv
// Directed bench for gate_model_seq: table-driven sweep runs on two small
// instances, plus hand-written reset, start-collision and stream sequences.
module tb_gate_model_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  gate_model_seq_if #(.N_IN(2),  .N_OUT(10)) ifa ();
  gate_model_seq_if #(.N_IN(2),  .N_OUT(10)) ifb ();
  gate_model_seq_if #(.N_IN(13), .N_OUT(10)) ifc ();

  // Gate models: A and B are tied to zero; C echoes its low input bits.
  assign ifa.dut_out = '0;
  assign ifb.dut_out = '0;
  assign ifc.dut_out = ifc.dut_in[9:0];

  gate_model_seq #(.N_IN(2),  .N_OUT(10), .SETTLE(2)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  gate_model_seq #(.N_IN(2),  .N_OUT(10), .SETTLE(0)) u_b (.clk(clk), .rst(rst), .bus(ifb));
  gate_model_seq #(.N_IN(13), .N_OUT(10), .SETTLE(2)) u_c (.clk(clk), .rst(rst), .bus(ifc));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [9:0] d);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb} ^ {6'b0, d};
  endfunction

  typedef struct packed {
    logic        sel_b;
    logic [15:0] exp_sig;
    logic        exp_pass;
    logic [7:0]  exp_done;
    logic [15:0] exp_signature;
    logic [15:0] exp_count;
  } sweep_vec_t;

  sweep_vec_t tbl [4];

  task automatic run_sweep(input sweep_vec_t v, input int idx);
    int done_cyc;
    int done_cnt;
    int ready_hi;
    int last_cyc;
    logic d, rdy, bz, ps;
    logic [1:0] din;
    logic [15:0] sg, cnt;
    done_cyc = -1;
    done_cnt = 0;
    ready_hi = 0;
    last_cyc = int'(v.exp_done) + 1;
    @(negedge clk);
    if (v.sel_b) begin ifb.exp_sig = v.exp_sig; ifb.mode = 1'b0; ifb.start = 1'b1; end
    else         begin ifa.exp_sig = v.exp_sig; ifa.mode = 1'b0; ifa.start = 1'b1; end
    for (int cyc = 1; cyc <= last_cyc; cyc++) begin
      @(negedge clk);
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      if (v.sel_b) begin
        d = ifb.done; rdy = ifb.vec_ready; bz = ifb.busy; ps = ifb.pass;
        din = ifb.dut_in; sg = ifb.signature; cnt = ifb.vec_count;
      end else begin
        d = ifa.done; rdy = ifa.vec_ready; bz = ifa.busy; ps = ifa.pass;
        din = ifa.dut_in; sg = ifa.signature; cnt = ifa.vec_count;
      end
      if (d) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (rdy) ready_hi++;
      if (!v.sel_b && cyc >= 2 && cyc <= 14 && ((cyc - 2) % 4) == 0)
        check($sformatf("run%0d_dut_in_c%0d", idx, cyc), 32'(din), 32'((cyc - 2) / 4));
      if (cyc == last_cyc) begin
        check($sformatf("run%0d_signature", idx), 32'(sg), 32'(v.exp_signature));
        check($sformatf("run%0d_vec_count", idx), 32'(cnt), 32'(v.exp_count));
        check($sformatf("run%0d_pass", idx), 32'(ps), 32'(v.exp_pass));
        check($sformatf("run%0d_busy_after", idx), 32'(bz), 32'd0);
        check($sformatf("run%0d_dut_in_hold", idx), 32'(din), 32'd3);
      end
    end
    check($sformatf("run%0d_done_cycle", idx), 32'(done_cyc), 32'(v.exp_done));
    check($sformatf("run%0d_done_pulses", idx), 32'(done_cnt), 32'd1);
    check($sformatf("run%0d_ready_in_sweep", idx), 32'(ready_hi), 32'd0);
  endtask

  initial begin
    logic [12:0] vecs [3];
    logic [15:0] exp_s;
    int idx, gap, ready_hi, done_cnt, post;
    logic chk_pending, hs, rdy_s;

    tbl[0] = '{sel_b: 1'b0, exp_sig: 16'hFFF0, exp_pass: 1'b1, exp_done: 8'd17,
               exp_signature: 16'hFFF0, exp_count: 16'd4};
    tbl[1] = '{sel_b: 1'b0, exp_sig: 16'h0000, exp_pass: 1'b0, exp_done: 8'd17,
               exp_signature: 16'hFFF0, exp_count: 16'd4};
    tbl[2] = '{sel_b: 1'b1, exp_sig: 16'hFFF0, exp_pass: 1'b1, exp_done: 8'd9,
               exp_signature: 16'hFFF0, exp_count: 16'd4};
    tbl[3] = '{sel_b: 1'b1, exp_sig: 16'h1234, exp_pass: 1'b0, exp_done: 8'd9,
               exp_signature: 16'hFFF0, exp_count: 16'd4};

    vecs[0] = 13'h0001;
    vecs[1] = 13'h1A55;
    vecs[2] = 13'h0FFF;

    ifa.start = 0; ifa.mode = 0; ifa.vec_valid = 0; ifa.vec_data = '0; ifa.vec_last = 0; ifa.exp_sig = '0;
    ifb.start = 0; ifb.mode = 0; ifb.vec_valid = 0; ifb.vec_data = '0; ifb.vec_last = 0; ifb.exp_sig = '0;
    ifc.start = 0; ifc.mode = 0; ifc.vec_valid = 0; ifc.vec_data = '0; ifc.vec_last = 0; ifc.exp_sig = '0;
    rst = 1'b1;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_a_busy", 32'(ifa.busy), 0);
    check("rst_a_done", 32'(ifa.done), 0);
    check("rst_a_pass", 32'(ifa.pass), 0);
    check("rst_a_sig", 32'(ifa.signature), 32'hFFFF);
    check("rst_a_count", 32'(ifa.vec_count), 0);
    check("rst_a_dut_in", 32'(ifa.dut_in), 0);
    check("rst_c_ready", 32'(ifc.vec_ready), 0);
    check("rst_c_sig", 32'(ifc.signature), 32'hFFFF);
    check("rst_c_dut_in", 32'(ifc.dut_in), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven sweep runs.
    for (int i = 0; i < 4; i++) run_sweep(tbl[i], i);

    // Reset during SETTLE of the second vector on instance A.
    @(negedge clk);
    ifa.exp_sig = 16'hFFF0;
    ifa.start = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      ifa.start = 1'b0;
    end
    check("midrst_pre_count", 32'(ifa.vec_count), 1);
    check("midrst_pre_sig", 32'(ifa.signature), 32'hFFFE);
    check("midrst_pre_busy", 32'(ifa.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(ifa.busy), 0);
    check("midrst_sig", 32'(ifa.signature), 32'hFFFF);
    check("midrst_count", 32'(ifa.vec_count), 0);
    check("midrst_dut_in", 32'(ifa.dut_in), 0);
    check("midrst_done", 32'(ifa.done), 0);
    done_cnt = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (ifa.done) done_cnt++;
    end
    check("midrst_no_done", 32'(done_cnt), 0);
    check("midrst_idle", 32'(ifa.busy), 0);

    // start while busy, start during done, then start one cycle after done.
    @(negedge clk);
    ifa.exp_sig = 16'hFFF0;
    ifa.start = 1'b1;
    done_cnt = 0;
    for (int cyc = 1; cyc <= 36; cyc++) begin
      @(negedge clk);
      ifa.start = 1'b0;
      if (cyc == 5) ifa.start = 1'b1;
      if (cyc == 17) begin
        check("coll_done_c17", 32'(ifa.done), 1);
        check("coll_sig_c17", 32'(ifa.signature), 32'hFFF0);
        ifa.start = 1'b1;
      end
      if (cyc == 18) begin
        check("coll_busy_c18", 32'(ifa.busy), 0);
        check("coll_pass_c18", 32'(ifa.pass), 1);
        ifa.start = 1'b1;
      end
      if (cyc == 19) begin
        check("restart_busy", 32'(ifa.busy), 1);
        check("restart_pass_clr", 32'(ifa.pass), 0);
        check("restart_sig_seed", 32'(ifa.signature), 32'hFFFF);
        check("restart_count_clr", 32'(ifa.vec_count), 0);
      end
      if (ifa.done) done_cnt++;
      if (cyc == 35) check("restart_done_c35", 32'(ifa.done), 1);
    end
    check("coll_done_pulses", 32'(done_cnt), 2);

    // Stream run on instance C with three-cycle valid stalls in FETCH.
    exp_s = 16'hFFFF;
    for (int i = 0; i < 3; i++) exp_s = misr_step(exp_s, vecs[i][9:0]);
    idx = 0; gap = 0; ready_hi = 0; done_cnt = 0; post = 0; chk_pending = 1'b0;
    @(negedge clk);
    ifc.exp_sig = exp_s;
    ifc.mode = 1'b1;
    ifc.start = 1'b1;
    ifc.vec_valid = 1'b0;
    @(posedge clk);
    for (int cyc = 1; cyc < 200; cyc++) begin
      @(negedge clk);
      ifc.start = 1'b0;
      ifc.mode = 1'b0;
      if (chk_pending) begin
        check($sformatf("stream_dut_in_v%0d", idx - 1), 32'(ifc.dut_in), 32'(vecs[idx-1]));
        chk_pending = 1'b0;
      end
      if (ifc.done) done_cnt++;
      rdy_s = ifc.vec_ready;
      if (rdy_s) ready_hi++;
      if (rdy_s && idx < 3 && gap >= 3) begin
        ifc.vec_valid = 1'b1;
        ifc.vec_data = vecs[idx];
        ifc.vec_last = (idx == 2);
      end else if (!rdy_s) begin
        ifc.vec_valid = 1'b1;
        ifc.vec_data = 13'h1FFF;
        ifc.vec_last = 1'b1;
      end else begin
        ifc.vec_valid = 1'b0;
        ifc.vec_data = 13'($urandom);
        ifc.vec_last = 1'b1;
      end
      hs = ifc.vec_valid && rdy_s;
      @(posedge clk);
      if (hs) begin
        idx++;
        gap = 0;
        chk_pending = 1'b1;
      end else if (rdy_s) begin
        gap++;
      end
      if (done_cnt > 0) post++;
      if (post >= 5) break;
    end
    @(negedge clk);
    ifc.vec_valid = 1'b0;
    check("stream_accepted", 32'(idx), 3);
    check("stream_done_pulses", 32'(done_cnt), 1);
    check("stream_ready_cycles", 32'(ready_hi), 12);
    check("stream_vec_count", 32'(ifc.vec_count), 3);
    check("stream_signature", 32'(ifc.signature), 32'(exp_s));
    check("stream_pass", 32'(ifc.pass), 1);
    check("stream_dut_in_hold", 32'(ifc.dut_in), 32'h0FFF);
    check("stream_idle", 32'(ifc.busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
